// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline controller for the 6-stage core.
//
// Merges per-stage stall requests into a hold vector, arbitrates EX/ID branch
// redirects and holds the winner until the PC register accepts it, generates
// wrong-path flushes for IF/ID, and keeps saturating performance counters.
//
// Ports:
//   clk                 single clock, rising edge
//   rst                 asynchronous reset, active low
//   stallreq_if/id/ex/mem  per-stage stall requests
//   ex_b_flag_i / ex_b_target_addr_i  EX taken branch/jump and target
//   id_b_flag_i / id_b_target_addr_i  ID direct jump and target
//   stall[5:0]          hold vector: 0=PC 1=IF 2=ID 3=EX 4=MEM 5=WB
//   redirect_valid_o / redirect_addr_o  pending redirect to the PC register
//   flush_if_o / flush_id_o            kill IF/ID and ID/EX latch contents
//   stall_cycles_o      cycles with stall[0]=1 (saturating)
//   redirect_cnt_o      redirects accepted by the PC register (saturating)
//
// Redirect FSM:
//   state   | meaning
//   IDLE    | no redirect pending
//   PEND_ID | ID redirect pending, may be overridden by EX
//   PEND_EX | EX redirect pending, ID redirects are wrong-path and dropped
module pipe_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              ex_b_flag_i,
  input  logic [ADDR_W-1:0] ex_b_target_addr_i,
  input  logic              id_b_flag_i,
  input  logic [ADDR_W-1:0] id_b_target_addr_i,
  output logic [5:0]        stall,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_addr_o,
  output logic              flush_if_o,
  output logic              flush_id_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  redirect_cnt_o
);

  typedef enum logic [1:0] {IDLE, PEND_ID, PEND_EX} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              consume;

  // Highest requesting stage wins; it holds itself and everything upstream.
  always_comb begin
    stall = 6'b000000;
    if (stallreq_mem)      stall = 6'b011111;
    else if (stallreq_ex)  stall = 6'b001111;
    else if (stallreq_id)  stall = 6'b000111;
    else if (stallreq_if)  stall = 6'b000011;
  end

  assign consume = (state != IDLE) && !stall[0];

  // Capture outranks consumption; the consumed redirect is still counted.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    if (ex_b_flag_i) begin
      state_nxt = PEND_EX;
      addr_nxt  = ex_b_target_addr_i;
    end else if (id_b_flag_i && state != PEND_EX) begin
      state_nxt = PEND_ID;
      addr_nxt  = id_b_target_addr_i;
    end else if (consume) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_o <= '0;
      redirect_cnt_o <= '0;
    end else begin
      if (stall[0] && stall_cycles_o != CNT_MAX)
        stall_cycles_o <= stall_cycles_o + CNT_ONE;
      if (consume && redirect_cnt_o != CNT_MAX)
        redirect_cnt_o <= redirect_cnt_o + CNT_ONE;
    end
  end

  assign redirect_valid_o = (state != IDLE);
  assign redirect_addr_o  = addr_q;
  assign flush_id_o       = ex_b_flag_i;
  // IF stays squashed until the PC has actually moved to the target.
  assign flush_if_o       = ex_b_flag_i | id_b_flag_i | redirect_valid_o;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stallreq_if = 0, stallreq_id = 0, stallreq_ex = 0, stallreq_mem = 0;
  logic              ex_b_flag_i = 0, id_b_flag_i = 0;
  logic [ADDR_W-1:0] ex_b_target_addr_i = '0, id_b_target_addr_i = '0;
  logic [5:0]        stall;
  logic              redirect_valid_o, flush_if_o, flush_id_o;
  logic [ADDR_W-1:0] redirect_addr_o;
  logic [CNT_W-1:0]  stall_cycles_o, redirect_cnt_o;

  int total = 0;
  int passed = 0;

  // Reference model: a pending redirect (valid/addr/from EX) plus two counts.
  logic        m_valid;
  logic [31:0] m_addr;
  logic        m_from_ex;
  int          m_stall_cnt, m_redir_cnt;

  pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .ex_b_flag_i(ex_b_flag_i), .ex_b_target_addr_i(ex_b_target_addr_i),
    .id_b_flag_i(id_b_flag_i), .id_b_target_addr_i(id_b_target_addr_i),
    .stall(stall), .redirect_valid_o(redirect_valid_o),
    .redirect_addr_o(redirect_addr_o), .flush_if_o(flush_if_o),
    .flush_id_o(flush_id_o), .stall_cycles_o(stall_cycles_o),
    .redirect_cnt_o(redirect_cnt_o)
  );

  always #5 clk = ~clk;

  // Number of held stages = index of requesting stage + 1 (PC counts as stage 0).
  function automatic logic [5:0] ref_stall();
    int n;
    n = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
    return 6'((1 << n) - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    check("stall", 32'(stall), 32'(ref_stall()));
    check("flush_id", 32'(flush_id_o), 32'(ex_b_flag_i));
    check("flush_if", 32'(flush_if_o), 32'(ex_b_flag_i | id_b_flag_i | m_valid));
    check("valid", 32'(redirect_valid_o), 32'(m_valid));
    check("addr", redirect_addr_o, m_addr);
    check("stall_cnt", 32'(stall_cycles_o), 32'(m_stall_cnt));
    check("redir_cnt", 32'(redirect_cnt_o), 32'(m_redir_cnt));
  endtask

  task automatic model_edge();
    logic [5:0] s;
    logic consumed;
    s = ref_stall();
    consumed = m_valid && !s[0];
    if (s[0]) m_stall_cnt = (m_stall_cnt < CNT_MAX) ? m_stall_cnt + 1 : CNT_MAX;
    if (consumed) m_redir_cnt = (m_redir_cnt < CNT_MAX) ? m_redir_cnt + 1 : CNT_MAX;
    if (ex_b_flag_i) begin
      m_valid = 1; m_addr = ex_b_target_addr_i; m_from_ex = 1;
    end else if (id_b_flag_i && !(m_valid && m_from_ex)) begin
      m_valid = 1; m_addr = id_b_target_addr_i; m_from_ex = 0;
    end else if (consumed) begin
      m_valid = 0; m_from_ex = 0;
    end
  endtask

  // Called just after a falling edge with inputs set: check, clock, advance model.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_valid = 0; m_addr = '0; m_from_ex = 0; m_stall_cnt = 0; m_redir_cnt = 0;
  endtask

  task automatic clear_inputs();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    ex_b_flag_i = 0; id_b_flag_i = 0;
  endtask

  // Asynchronous reset applied mid-cycle; effect checked before any clock edge.
  task automatic do_reset();
    rst = 0;
    model_reset();
    #1;
    check("rst_valid", 32'(redirect_valid_o), 32'd0);
    check("rst_stall_cnt", 32'(stall_cycles_o), 32'd0);
    check("rst_redir_cnt", 32'(redirect_cnt_o), 32'd0);
    check_all();
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    model_reset();
    clear_inputs();
    @(negedge clk);
    do_reset();

    // Stall vector priority
    stallreq_id = 1; #1 check("stall_id", 32'(stall), 32'h07); step();
    stallreq_mem = 1; #1 check("stall_mem", 32'(stall), 32'h1f); step();
    clear_inputs(); step();

    // Single EX redirect, no stalls
    do_reset();
    ex_b_flag_i = 1; ex_b_target_addr_i = 32'h100;
    #1 check("ex_flush_id", 32'(flush_id_o), 32'd1);
    check("ex_flush_if", 32'(flush_if_o), 32'd1);
    step();
    clear_inputs();
    #1 check("ex_valid", 32'(redirect_valid_o), 32'd1);
    check("ex_addr", redirect_addr_o, 32'h100);
    step();
    #1 check("ex_idle", 32'(redirect_valid_o), 32'd0);
    check("ex_cnt", 32'(redirect_cnt_o), 32'd1);
    step();

    // EX and ID in the same cycle; later ID in PEND_EX dropped
    do_reset();
    id_b_flag_i = 1; id_b_target_addr_i = 32'h40;
    ex_b_flag_i = 1; ex_b_target_addr_i = 32'h80;
    step();
    clear_inputs();
    stallreq_ex = 1; id_b_flag_i = 1; id_b_target_addr_i = 32'h44;
    #1 check("both_addr", redirect_addr_o, 32'h80);
    step();
    id_b_flag_i = 0;
    #1 check("pend_ex_keep", redirect_addr_o, 32'h80);
    check("pend_ex_valid", 32'(redirect_valid_o), 32'd1);
    step();
    clear_inputs(); step(); step();

    // ID pending under stall, overwritten by EX
    do_reset();
    id_b_flag_i = 1; id_b_target_addr_i = 32'h40; step();
    clear_inputs(); stallreq_ex = 1;
    #1 check("id_addr", redirect_addr_o, 32'h40);
    step();
    ex_b_flag_i = 1; ex_b_target_addr_i = 32'h200; step();
    ex_b_flag_i = 0;
    #1 check("ovr_addr", redirect_addr_o, 32'h200);
    check("ovr_cnt0", 32'(redirect_cnt_o), 32'd0);
    step();
    stallreq_ex = 0;
    #1 check("ovr_held", 32'(redirect_valid_o), 32'd1);
    step();
    #1 check("ovr_cnt1", 32'(redirect_cnt_o), 32'd1);
    check("ovr_idle", 32'(redirect_valid_o), 32'd0);
    step();

    // Stall counter and saturation
    do_reset();
    stallreq_if = 1;
    repeat (10) step();
    stallreq_if = 0;
    #1 check("stall_cnt10", 32'(stall_cycles_o), 32'd10);
    stallreq_if = 1;
    repeat (10) step();
    stallreq_if = 0;
    #1 check("stall_cnt_sat", 32'(stall_cycles_o), 32'd15);
    step();

    // Async reset while PEND_EX
    do_reset();
    stallreq_mem = 1; step();
    ex_b_flag_i = 1; ex_b_target_addr_i = 32'h300; step();
    ex_b_flag_i = 0;
    #1 check("pre_rst_valid", 32'(redirect_valid_o), 32'd1);
    #2;
    clear_inputs();
    do_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        clear_inputs();
        do_reset();
      end
      stallreq_if  = ($urandom_range(0, 3) == 0);
      stallreq_id  = ($urandom_range(0, 5) == 0);
      stallreq_ex  = ($urandom_range(0, 5) == 0);
      stallreq_mem = ($urandom_range(0, 7) == 0);
      ex_b_flag_i  = ($urandom_range(0, 4) == 0);
      id_b_flag_i  = ($urandom_range(0, 3) == 0);
      ex_b_target_addr_i = $urandom;
      id_b_target_addr_i = $urandom;
      step();
    end
    clear_inputs();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
